// File: rtl/sfft_pkg.sv
// Shared types and constants for the split-FFT frame scheduler.
// State encodings, half-select codes and the frame length helper.
package sfft_pkg;

  typedef enum logic [2:0] {
    ST_RX,
    ST_EVEN_RUN,
    ST_ODD_LOAD,
    ST_ODD_RUN,
    ST_COMBINE
  } state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  function automatic int nfft(input int size_buffer);
    return 1 << size_buffer;
  endfunction

endpackage

// File: rtl/sfft_watchdog.sv
// Stall watchdog: clearable, enabled up-counter with a
// terminal-count flag for the frame scheduler.
module sfft_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [TIMEOUT_W-1:0] PRE_TC =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_en)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires on the edge that would make the count all-ones,
  // i.e. after 2^TIMEOUT_W-1 enabled cycles.
  assign o_tc = i_en && (cnt_q == PRE_TC);

endmodule

// File: rtl/sfft_frame_scheduler.sv
// Split-FFT frame scheduler: sample intake, half-core sequencing,
// combine hand-off and recovery from a stalled core.
module sfft_frame_scheduler
  import sfft_pkg::*;
#(
  parameter int SIZE_BUFFER = 3,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [SIZE_BUFFER:0] o_counter_data,
  output logic                 o_fft_start,
  output logic                 o_fft_half,
  input  logic                 i_fft_done,
  input  logic                 i_fft_load_req,
  output logic                 o_fft_wayt_data,
  input  logic                 i_wayt_data_second_NChet,
  output logic                 o_combine_start,
  input  logic                 i_combine_done,
  output logic                 o_frame_done,
  output logic                 o_busy,
  output logic                 o_datapath_reset,
  output logic                 o_error
);

  localparam int NFFT = nfft(SIZE_BUFFER);
  localparam logic [SIZE_BUFFER:0] LAST_IDX =
    (SIZE_BUFFER+1)'(NFFT - 1);
  localparam logic [SIZE_BUFFER:0] IDX_ONE =
    (SIZE_BUFFER+1)'(1);

  state_e               state_q, state_d;
  logic [SIZE_BUFFER:0] cnt_q, cnt_d;
  logic start_q, start_d;
  logic half_q, half_d;
  logic comb_q, comb_d;
  logic frame_q, frame_d;
  logic dpr_q, dpr_d;
  logic err_q, err_d;
  logic odd_sent, proto_err;
  logic wd_tc, wd_clr, wd_en;

  assign odd_sent = !i_wayt_data_second_NChet;

  assign proto_err =
    (i_fft_done && (state_q inside
      {ST_RX, ST_ODD_LOAD, ST_COMBINE})) ||
    (i_combine_done && state_q != ST_COMBINE) ||
    (odd_sent && state_q != ST_ODD_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    half_d  = half_q;
    comb_d  = 1'b0;
    frame_d = 1'b0;
    dpr_d   = 1'b0;
    unique case (state_q)
      ST_RX: if (i_valid) begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_EVEN_RUN;
          start_d = 1'b1;
          half_d  = EVEN;
        end else begin
          cnt_d = cnt_q + IDX_ONE;
        end
      end
      ST_EVEN_RUN: if (i_fft_done)
        state_d = ST_ODD_LOAD;
      ST_ODD_LOAD: if (odd_sent) begin
        state_d = ST_ODD_RUN;
        start_d = 1'b1;
        half_d  = ODD;
      end
      ST_ODD_RUN: if (i_fft_done) begin
        state_d = ST_COMBINE;
        comb_d  = 1'b1;
      end
      ST_COMBINE: if (i_combine_done) begin
        state_d = ST_RX;
        frame_d = 1'b1;
      end
      default: state_d = ST_RX;
    endcase
    // A legal completion in the timeout cycle wins.
    if (wd_tc && state_d == state_q) begin
      state_d = ST_RX;
      cnt_d   = '0;
      dpr_d   = 1'b1;
    end
    err_d = err_q | proto_err | dpr_d;
  end

  assign wd_clr = (state_d != state_q);
  assign wd_en  = (state_q != ST_RX);

  sfft_watchdog #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_wd (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (wd_clr),
    .i_en   (wd_en),
    .o_tc   (wd_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
      start_q <= 1'b0;
      half_q  <= EVEN;
      comb_q  <= 1'b0;
      frame_q <= 1'b0;
      dpr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      half_q  <= half_d;
      comb_q  <= comb_d;
      frame_q <= frame_d;
      dpr_q   <= dpr_d;
      err_q   <= err_d;
    end
  end

  assign o_ready          = (state_q == ST_RX);
  assign o_busy           = (state_q != ST_RX);
  assign o_fft_wayt_data  =
    (state_q == ST_ODD_LOAD) && i_fft_load_req;
  assign o_counter_data   = cnt_q;
  assign o_fft_start      = start_q;
  assign o_fft_half       = half_q;
  assign o_combine_start  = comb_q;
  assign o_frame_done     = frame_q;
  assign o_datapath_reset = dpr_q;
  assign o_error          = err_q;

endmodule

// File: tb/tb_sfft_frame_scheduler.sv
// Self-checking bench for sfft_frame_scheduler (SIZE_BUFFER=3,
// TIMEOUT_W=4) using expected-index and expected-event queues.
module tb_sfft_frame_scheduler;

  localparam int EV_EVEN  = 1;
  localparam int EV_ODD   = 2;
  localparam int EV_COMB  = 3;
  localparam int EV_FRAME = 4;
  localparam int EV_DPR   = 5;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_fft_done = 1'b0;
  logic       i_fft_load_req = 1'b0;
  logic       i_second = 1'b1;
  logic       i_combine_done = 1'b0;
  logic       o_ready, o_fft_start, o_fft_half;
  logic       o_fft_wayt_data, o_combine_start;
  logic       o_frame_done, o_busy, o_datapath_reset, o_error;
  logic [3:0] o_counter_data;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int obs_idx[$];
  int exp_idx[$];
  int obs_ev[$];
  int exp_ev[$];
  int start_cyc, dpr_cyc, acc_cyc, n_wayt, n_rdy_busy;
  logic s_ready, s_busy, s_error, s_wayt, s_dpr;
  logic [3:0] s_cnt;

  sfft_frame_scheduler #(
    .SIZE_BUFFER(3),
    .TIMEOUT_W  (4)
  ) dut (
    .i_clk                   (clk),
    .i_reset                 (i_reset),
    .i_valid                 (i_valid),
    .o_ready                 (o_ready),
    .o_counter_data          (o_counter_data),
    .o_fft_start             (o_fft_start),
    .o_fft_half              (o_fft_half),
    .i_fft_done              (i_fft_done),
    .i_fft_load_req          (i_fft_load_req),
    .o_fft_wayt_data         (o_fft_wayt_data),
    .i_wayt_data_second_NChet(i_second),
    .o_combine_start         (o_combine_start),
    .i_combine_done          (i_combine_done),
    .o_frame_done            (o_frame_done),
    .o_busy                  (o_busy),
    .o_datapath_reset        (o_datapath_reset),
    .o_error                 (o_error)
  );

  always #5 clk = ~clk;

  // One cycle: observe at negedge, return 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    s_ready = o_ready;
    s_busy  = o_busy;
    s_error = o_error;
    s_wayt  = o_fft_wayt_data;
    s_dpr   = o_datapath_reset;
    s_cnt   = o_counter_data;
    if (i_valid && o_ready) begin
      obs_idx.push_back(int'(o_counter_data));
      acc_cyc = cyc;
    end
    if (o_fft_start === 1'b1) begin
      obs_ev.push_back(o_fft_half ? EV_ODD : EV_EVEN);
      if (o_fft_half === 1'b0) start_cyc = cyc;
    end
    if (o_combine_start === 1'b1) obs_ev.push_back(EV_COMB);
    if (o_frame_done === 1'b1) obs_ev.push_back(EV_FRAME);
    if (o_datapath_reset === 1'b1) begin
      obs_ev.push_back(EV_DPR);
      dpr_cyc = cyc;
    end
    if (o_fft_wayt_data === 1'b1) n_wayt++;
    if (o_ready === 1'b1 && o_busy === 1'b1) n_rdy_busy++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_idx.delete();
    exp_idx.delete();
    obs_ev.delete();
    exp_ev.delete();
    n_wayt = 0;
    n_rdy_busy = 0;
    start_cyc = -100;
    dpr_cyc = -100;
    acc_cyc = -100;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_obs();
    do_reset();
    i_fft_load_req = 1'b1;
    tick();
    i_fft_load_req = 1'b0;
    n_total++;
    if (s_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", s_ready);
    else n_pass++;
    n_total++;
    if (s_busy !== 1'b0)
      $display("FAIL reset_busy: got %b want 0", s_busy);
    else n_pass++;
    n_total++;
    if (s_error !== 1'b0)
      $display("FAIL reset_error: got %b want 0", s_error);
    else n_pass++;
    n_total++;
    if (s_cnt !== 4'd0)
      $display("FAIL reset_cnt: got %0d want 0", s_cnt);
    else n_pass++;
    n_total++;
    if (s_wayt !== 1'b0)
      $display("FAIL reset_wayt: got %b want 0", s_wayt);
    else n_pass++;
    n_total++;
    if (obs_ev.size() != 0)
      $display("FAIL reset_pulses: got %0d want 0", obs_ev.size());
    else n_pass++;
  endtask

  // Full frame: gap idle cycles between samples, valid held high
  // through the busy phase, optional spurious done at index 3.
  task automatic run_frame(input string nm, input int gap,
                           input bit hold, input bit spur);
    int last_acc;
    int e;
    int o;
    clear_obs();
    for (int i = 0; i < 8; i++) exp_idx.push_back(i);
    if (hold) exp_idx.push_back(0);
    exp_ev.push_back(EV_EVEN);
    exp_ev.push_back(EV_ODD);
    exp_ev.push_back(EV_COMB);
    exp_ev.push_back(EV_FRAME);
    for (int i = 0; i < 8; i++) begin
      if (spur && i == 3) begin
        i_fft_done = 1'b1;
        tick();
        i_fft_done = 1'b0;
        n_total++;
        if (o_error !== 1'b1)
          $display("FAIL %s_spur_err: got %b want 1", nm, o_error);
        else n_pass++;
        n_total++;
        if (o_ready !== 1'b1 || o_counter_data !== 4'd3)
          $display("FAIL %s_spur_hold: got rdy=%b cnt=%0d want 1 3",
                   nm, o_ready, o_counter_data);
        else n_pass++;
      end
      i_valid = 1'b1;
      tick();
      i_valid = hold;
      if (i < 7) repeat (gap) tick();
    end
    last_acc = acc_cyc;
    repeat (10) tick();
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    i_fft_load_req = 1'b1;
    repeat (4) tick();
    i_fft_load_req = 1'b0;
    i_second = 1'b0;
    tick();
    i_second = 1'b1;
    repeat (10) tick();
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    repeat (5) tick();
    i_combine_done = 1'b1;
    tick();
    i_combine_done = 1'b0;
    tick();
    i_valid = 1'b0;
    tick();
    while (exp_idx.size() > 0) begin
      e = exp_idx.pop_front();
      n_total++;
      if (obs_idx.size() == 0) begin
        $display("FAIL %s_idx: got none want %0d", nm, e);
      end else begin
        o = obs_idx.pop_front();
        if (o !== e)
          $display("FAIL %s_idx: got %0d want %0d", nm, o, e);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_idx.size() != 0)
      $display("FAIL %s_extra_idx: got %0d want 0", nm,
               obs_idx.size());
    else n_pass++;
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      n_total++;
      if (obs_ev.size() == 0) begin
        $display("FAIL %s_ev: got none want %0d", nm, e);
      end else begin
        o = obs_ev.pop_front();
        if (o !== e)
          $display("FAIL %s_ev: got %0d want %0d", nm, o, e);
        else n_pass++;
      end
    end
    n_total++;
    if (obs_ev.size() != 0)
      $display("FAIL %s_extra_ev: got %0d want 0", nm,
               obs_ev.size());
    else n_pass++;
    n_total++;
    if (start_cyc - last_acc != 1)
      $display("FAIL %s_start_lat: got %0d want 1", nm,
               start_cyc - last_acc);
    else n_pass++;
    n_total++;
    if (n_wayt != 4)
      $display("FAIL %s_wayt: got %0d want 4", nm, n_wayt);
    else n_pass++;
    n_total++;
    if (n_rdy_busy != 0)
      $display("FAIL %s_rdy_busy: got %0d want 0", nm, n_rdy_busy);
    else n_pass++;
    n_total++;
    if (o_error !== spur)
      $display("FAIL %s_error: got %b want %b", nm, o_error, spur);
    else n_pass++;
    if (!hold) begin
      n_total++;
      if (o_counter_data !== 4'd0 || o_ready !== 1'b1)
        $display("FAIL %s_end: got cnt=%0d rdy=%b want 0 1", nm,
                 o_counter_data, o_ready);
      else n_pass++;
    end
  endtask

  task automatic test_nominal();
    do_reset();
    run_frame("nominal", 0, 1'b0, 1'b0);
  endtask

  task automatic test_gappy();
    do_reset();
    run_frame("gappy", 2, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    run_frame("backpressure", 0, 1'b1, 1'b0);
  endtask

  task automatic test_spurious();
    do_reset();
    run_frame("spurious", 0, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    bit found;
    do_reset();
    clear_obs();
    exp_ev.push_back(EV_EVEN);
    exp_ev.push_back(EV_DPR);
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
    end
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (s_dpr === 1'b1) found = 1'b1;
    end
    n_total++;
    if (!found)
      $display("FAIL timeout_seen: got 0 want 1");
    else n_pass++;
    n_total++;
    if (dpr_cyc - start_cyc != 15)
      $display("FAIL timeout_lat: got %0d want 15",
               dpr_cyc - start_cyc);
    else n_pass++;
    n_total++;
    if (s_ready !== 1'b1 || s_busy !== 1'b0 || s_error !== 1'b1)
      $display("FAIL timeout_state: got rdy=%b busy=%b err=%b want 1 0 1",
               s_ready, s_busy, s_error);
    else n_pass++;
    tick();
    n_total++;
    if (s_dpr !== 1'b0)
      $display("FAIL timeout_pulse_len: got %b want 0", s_dpr);
    else n_pass++;
    n_total++;
    if (obs_ev.size() != exp_ev.size())
      $display("FAIL timeout_ev_cnt: got %0d want %0d",
               obs_ev.size(), exp_ev.size());
    else n_pass++;
    while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
      int e;
      int o;
      e = exp_ev.pop_front();
      o = obs_ev.pop_front();
      n_total++;
      if (o !== e)
        $display("FAIL timeout_ev: got %0d want %0d", o, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n_frame;
    do_reset();
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
    end
    repeat (10) tick();
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    i_fft_load_req = 1'b1;
    #1;
    n_total++;
    if (o_fft_wayt_data !== 1'b1)
      $display("FAIL rmid_in_load: got %b want 1", o_fft_wayt_data);
    else n_pass++;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    tick();
    n_total++;
    if (s_cnt !== 4'd0 || s_busy !== 1'b0 || s_wayt !== 1'b0)
      $display("FAIL rmid_after: got cnt=%0d busy=%b wayt=%b want 0 0 0",
               s_cnt, s_busy, s_wayt);
    else n_pass++;
    repeat (20) tick();
    i_fft_load_req = 1'b0;
    n_frame = 0;
    foreach (obs_ev[k]) if (obs_ev[k] == EV_FRAME) n_frame++;
    n_total++;
    if (n_frame != 0)
      $display("FAIL rmid_frame_done: got %0d want 0", n_frame);
    else n_pass++;
    n_total++;
    if (obs_ev.size() != 1)
      $display("FAIL rmid_events: got %0d want 1", obs_ev.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gappy();
    test_backpressure();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got stuck want finish");
    $fatal(1);
  end

endmodule
